multdiv_seq: RTL
================

# multdiv_seq

Sequential signed 32-bit multiply/divide unit for the processor's execute stage. A single shared 32-bit add/subtract datapath is sequenced over 32 iterations: radix-2 Booth for multiply, restoring division on magnitudes for divide. The pipeline issues an operation with a one-cycle control pulse, stalls, and consumes the result on a one-cycle ready pulse.

## Interface
- `ITER`, default 32: number of iteration cycles. Must equal the operand width.
- `clock`, in, 1: sole clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ctrl_MULT`, in, 1: start-multiply pulse.
- `ctrl_DIV`, in, 1: start-divide pulse.
- `data_operandA`, in, 32: multiplicand / dividend, two's complement. Sampled only on the start edge.
- `data_operandB`, in, 32: multiplier / divisor, two's complement. Sampled only on the start edge.
- `data_result`, out, 32: low product word or quotient. Registered.
- `data_exception`, out, 1: overflow or divide-by-zero. Registered.
- `data_resultRDY`, out, 1: one-cycle completion pulse.

## Operation
- **FSM states:** IDLE, MULT, DIV, FIX, DONE.
  - IDLE → MULT on `ctrl_MULT`.
  - IDLE → DIV on `ctrl_DIV`.
  - MULT or DIV → FIX after `ITER` iterations.
  - FIX → DONE.
  - DONE → IDLE.
- **Start priority:** `ctrl_MULT` and `ctrl_DIV` both high means multiply wins.
- **Restart:** a start pulse in any state, including MULT, DIV or FIX, aborts the current operation and restarts with the newly sampled operands. The aborted operation never produces `data_resultRDY`.
- **Multiply:**
  - 65-bit product register {A_hi[32], B[32], q−1}.
  - Each iteration adds 0, +A or −A to the upper part according to {q0, q−1}, then arithmetic-shifts right by 1.
  - In FIX: result = product[31:0]. Exception = 1 when product[63:32] is not all copies of product[31].
- **Divide:**
  - Uses |A| and |B|. Each iteration shifts the {remainder, quotient} pair left, trial-subtracts |B|, and restores the remainder if it went negative (setting quotient bit 0 when negative, 1 otherwise).
  - In FIX: quotient is negated when sign(A) ≠ sign(B), so the quotient truncates toward zero. The remainder is discarded.
  - B == 0: detected at the start edge. Skip straight to DONE with result 0 and exception 1.
  - A = 0x80000000 and B = 0xFFFFFFFF: result 0x80000000, exception 1.
- **Counter:** 6-bit iteration counter, cleared on start. The FSM leaves MULT/DIV when the counter reaches `ITER`−1.
- **Output holding:** `data_result` and `data_exception` update only on entering DONE. They hold their value until the next completion.
- **Reset:**
  - Takes effect at any point, including mid-operation. State goes to IDLE and all internal registers clear.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
  - A start pulse coincident with reset is ignored.

## Timing
- Start edge = T0, the rising edge where `ctrl_MULT` or `ctrl_DIV` is sampled high.
- Iterations occur on edges T1 through T32. The FIX computation happens on edge T33.
- On edge T34, `data_result` and `data_exception` load and `data_resultRDY` rises. `data_resultRDY` falls at T35.
- Latency is 34 cycles from T0 to the `data_resultRDY` rise.
- Divide-by-zero: outputs load and `data_resultRDY` rises at T1, falling at T2.
- Start pulses are level-sampled each edge. Holding a start high for N cycles restarts N times, so the operation begins at the last high edge.
- The earliest back-to-back start is on the same edge on which `data_resultRDY` falls.

## Configuration
- `MULTDIV_DIV_EN` defined: full divide path as described above.
- `MULTDIV_DIV_EN` undefined:
  - Divide datapath, restore logic and sign-fix logic are compiled out.
  - `ctrl_DIV` moves IDLE → DONE at T0, so `data_resultRDY` rises at T1 with result 0 and exception 1.
  - Multiply behaviour and timing are unchanged.

## Structure
- Package `multdiv_pkg` holds:
  - the FSM state enum;
  - `ITER_DEFAULT` = 32;
  - an op-select enum (OP_MULT, OP_DIV);
  - the Booth action encoding (NOP, ADD, SUB).
- Sub-module `addsub32`:
  - 32-bit add/subtract built from four 8-bit carry-lookahead blocks.
  - Inter-block carries come from group generate/propagate.
  - A `sub` input inverts B and sets carry-in to 1.
  - Outputs the sum and carry-out.
  - Multiply and divide share one instance.

## Test plan
- **Signed multiply:** A=7, B=−3 → `data_result` 0xFFFFFFEB, exception 0, `data_resultRDY` a single pulse exactly 34 edges after T0.
- **Multiply overflow:** A=0x00010000, B=0x00010000 → result 0x00000000, exception 1. Also A=0x7FFFFFFF, B=1 → result 0x7FFFFFFF, exception 0.
- **Signed divide:** A=−100, B=7 → result 0xFFFFFFF2 (−14), exception 0. A=100, B=−7 → −14. A=6, B=7 → 0.
- **Divide edge cases:**
  - A=5, B=0 → result 0, exception 1, `data_resultRDY` at T1.
  - A=0x80000000, B=−1 → result 0x80000000, exception 1.
  - With `MULTDIV_DIV_EN` undefined, any `ctrl_DIV` → exception 1 at T1.
- **Restart:** `ctrl_DIV` with 100/7, then `ctrl_MULT` with 3×4 at T10 → exactly one `data_resultRDY`, 34 edges after the multiply start, with result 12. Both starts high on one edge → multiply result.
- **Reset mid-operation:** `reset` at T15 of a multiply → outputs 0, no `data_resultRDY` within 40 cycles. The next `ctrl_MULT` with 2×2 → result 4 at T34.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit:
// FSM states, operation select, Booth action encoding, operand magnitude.
package multdiv_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_e;

  // {q0, q-1} = 01 ends a run of ones (add), 10 starts one (subtract)
  function automatic booth_e booth_decode(input logic [1:0] qpair);
    case (qpair)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

  // 0x80000000 maps to itself, which is its correct unsigned magnitude
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_seq_addsub32.sv
// 32-bit adder/subtractor from four 8-bit carry-lookahead groups; the
// group generate/propagate terms produce the carries between groups.
module addsub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] bx;
  logic [31:0] g;
  logic [31:0] p;

  assign bx = b ^ {32{sub}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  always_comb begin
    logic carry;
    logic gg;
    logic gp;
    logic cc;
    sum   = '0;
    carry = sub;
    for (int k = 0; k < 4; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < 8; i++) begin
        gg = g[8*k+i] | (p[8*k+i] & gg);
        gp = gp & p[8*k+i];
      end
      cc = carry;
      for (int i = 0; i < 8; i++) begin
        sum[8*k+i] = p[8*k+i] ^ cc;
        cc         = g[8*k+i] | (p[8*k+i] & cc);
      end
      carry = gg | (gp & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Define MULTDIV_DIV_EN to build the divide path; otherwise ctrl_DIV reports an exception.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam logic [2:0] IDLE = S_IDLE;
  localparam logic [2:0] MULT = S_MULT;
  localparam logic [2:0] DIV  = S_DIV;
  localparam logic [2:0] FIX  = S_FIX;
  localparam logic [2:0] DONE = S_DONE;

  logic [2:0]  state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        qm1;
  logic [31:0] mcand;
  logic [5:0]  cnt;
  logic [31:0] fix_res;
  logic        fix_exc;

`ifdef MULTDIV_DIV_EN
  op_e         op;
  logic        negq;
  logic        pend_exc;
  logic [31:0] rsh;
  logic        nonneg;
`endif

  booth_e      act;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_sub;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] new_hi;
  logic        top;

  assign act = booth_decode({lo[0], qm1});

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state)
      MULT: begin
        add_a   = hi;
        add_b   = mcand;
        add_sub = (act == BOOTH_SUB);
      end
`ifdef MULTDIV_DIV_EN
      DIV: begin
        add_a   = {hi[30:0], lo[31]};
        add_b   = mcand;
        add_sub = 1'b1;
      end
      FIX: begin
        if (op == OP_DIV) begin
          add_b   = lo;
          add_sub = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  addsub32 u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum),
    .cout(cout)
  );

  // The 33rd sum bit is rebuilt from the carry so the arithmetic shift stays exact
  always_comb begin
    new_hi = (act == BOOTH_NOP) ? hi : sum;
    top    = (act == BOOTH_NOP) ? hi[31] : (hi[31] ^ mcand[31] ^ add_sub ^ cout);
  end

`ifdef MULTDIV_DIV_EN
  // Shifted-out remainder bit covers trial differences wider than 32 bits
  always_comb begin
    rsh    = {hi[30:0], lo[31]};
    nonneg = hi[31] | cout;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      hi             <= '0;
      lo             <= '0;
      qm1            <= 1'b0;
      mcand          <= '0;
      cnt            <= '0;
      fix_res        <= '0;
      fix_exc        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIV_EN
      op             <= OP_MULT;
      negq           <= 1'b0;
      pend_exc       <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MULT;
        hi    <= '0;
        lo    <= data_operandB;
        qm1   <= 1'b0;
        mcand <= data_operandA;
        cnt   <= '0;
`ifdef MULTDIV_DIV_EN
        op    <= OP_MULT;
`endif
      end else if (ctrl_DIV) begin
        cnt <= '0;
`ifdef MULTDIV_DIV_EN
        op       <= OP_DIV;
        hi       <= '0;
        lo       <= mag32(data_operandA);
        mcand    <= mag32(data_operandB);
        negq     <= data_operandA[31] ^ data_operandB[31];
        pend_exc <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        if (data_operandB == '0) begin
          state   <= DONE;
          fix_res <= '0;
          fix_exc <= 1'b1;
        end else begin
          state <= DIV;
        end
`else
        state   <= DONE;
        fix_res <= '0;
        fix_exc <= 1'b1;
`endif
      end else begin
        case (state)
          MULT: begin
            hi  <= {top, new_hi[31:1]};
            lo  <= {new_hi[0], lo[31:1]};
            qm1 <= lo[0];
            cnt <= cnt + 6'd1;
            if (cnt == 6'(ITER - 1)) state <= FIX;
          end
          DIV: begin
`ifdef MULTDIV_DIV_EN
            hi  <= nonneg ? sum : rsh;
            lo  <= {lo[30:0], nonneg};
            cnt <= cnt + 6'd1;
            if (cnt == 6'(ITER - 1)) state <= FIX;
`else
            state <= IDLE;
`endif
          end
          FIX: begin
            state <= DONE;
`ifdef MULTDIV_DIV_EN
            if (op == OP_DIV) begin
              fix_res <= negq ? sum : lo;
              fix_exc <= pend_exc;
            end else
`endif
            begin
              fix_res <= lo;
              fix_exc <= (hi != {32{lo[31]}});
            end
          end
          DONE: begin
            data_result    <= fix_res;
            data_exception <= fix_exc;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
